// File: rtl/serial_sub4.sv
// Bit-serial subtractor: resolves A - B - Bin one bit per clock, LSB first,
// then presents DIFF/Bout with a one-cycle done pulse.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last result
// SHIFT | one bit resolved per clock; last bit loads DIFF/Bout and done
module serial_sub4 #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] DIFF,
   output logic             Bout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic [WIDTH-1:0] res_nxt;
   logic             borrow;
   logic             borrow_nxt;
   logic             d_bit;
   logic             last_bit;
   logic [CW-1:0]    cnt;

   always_comb begin
      state_nxt  = state;
      d_bit      = a_sr[0] ^ b_sr[0] ^ borrow;
      borrow_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);
      // New bit enters at the MSB so the result is aligned after WIDTH shifts.
      res_nxt            = res_sr >> 1;
      res_nxt[WIDTH-1]   = d_bit;
      last_bit           = (cnt == LAST);
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (last_bit) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == SHIFT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
         DIFF   <= '0;
         Bout   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr   <= A;
                  b_sr   <= B;
                  borrow <= Bin;
                  res_sr <= '0;
                  cnt    <= '0;
               end
            end
            SHIFT: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= res_nxt;
               borrow <= borrow_nxt;
               if (last_bit) begin
                  DIFF <= res_nxt;
                  Bout <= borrow_nxt;
                  done <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_sub4.sv
// Directed and exhaustive-shuffled checks of serial_sub4 against an
// arithmetic reference and a fulladd4-style recombination check.
module tb_serial_sub4;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Bin;
   logic         busy;
   logic         done;
   logic [W-1:0] DIFF;
   logic         Bout;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   serial_sub4 #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Bin(Bin),
      .busy(busy), .done(done), .DIFF(DIFF), .Bout(Bout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] ref_sub(input logic [3:0] a, input logic [3:0] b, input logic bin);
      int d;
      d = int'(a) - int'(b) - int'(bin);
      return {d < 0, d[3:0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits up to a bounded number of edges for done; returns edges elapsed.
   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < W + 4) begin
         tick();
         n++;
      end
   endtask

   task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bin,
                         input string tag, input bit full);
      int n;
      logic [4:0] exp;
      logic [4:0] sum;
      exp   = ref_sub(a, b, bin);
      A     = a;
      B     = b;
      Bin   = bin;
      start = 1'b1;
      tick();
      start = 1'b0;
      A     = 4'($urandom);
      B     = 4'($urandom);
      Bin   = 1'($urandom);
      if (full) check({tag, "_busy"}, 32'(busy), 32'd1);
      wait_done(n);
      if (full) begin
         check({tag, "_done"}, 32'(done), 32'd1);
         check({tag, "_lat"}, 32'(n), 32'(W));
         check({tag, "_idle"}, 32'(busy), 32'd0);
      end
      check({tag, "_diff"}, 32'({Bout, DIFF}), 32'(exp));
      sum = 5'(DIFF) + 5'(b) + 5'(bin);
      check({tag, "_fa4"}, 32'(sum), 32'({Bout, a}));
      tick();
      if (full) check({tag, "_pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      int n;
      int t1;
      int order [512];
      rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
      tick(); tick();
      check("rst_outs", 32'({busy, done, Bout, DIFF}), 32'd0);
      rst = 1'b0;
      tick();

      run_op(4'b0000, 4'b0001, 1'b0, "t0", 1'b1);
      run_op(4'b0011, 4'b0011, 1'b0, "t1", 1'b1);
      run_op(4'b0011, 4'b0001, 1'b1, "t2", 1'b1);
      run_op(4'b1111, 4'b1011, 1'b0, "t3", 1'b1);
      run_op(4'b0000, 4'b0000, 1'b1, "t4", 1'b1);

      // Back-to-back with start held high.
      A = 4'b0101; B = 4'b0010; Bin = 1'b0; start = 1'b1;
      tick();
      A = 4'b1110; B = 4'b0111; Bin = 1'b1;
      wait_done(n);
      t1 = cyc;
      check("b2b_done1", 32'(done), 32'd1);
      check("b2b_res1", 32'({Bout, DIFF}), 32'h03);
      A = 4'b0010; B = 4'b0101; Bin = 1'b0;
      tick();
      check("b2b_accept", 32'(busy), 32'd1);
      A = 4'b1001; B = 4'b0000;
      wait_done(n);
      check("b2b_done2", 32'(done), 32'd1);
      check("b2b_gap", 32'(cyc - t1), 32'(W + 1));
      check("b2b_res2", 32'({Bout, DIFF}), 32'h1D);
      start = 1'b0;
      tick();
      wait_done(n);
      tick();
      check("b2b_quiet", 32'({busy, done}), 32'd0);

      // Reset mid-operation.
      A = 4'b1000; B = 4'b0001; Bin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_outs", 32'({busy, done, Bout, DIFF}), 32'd0);
      wait_done(n);
      check("mid_rst_nodone", 32'(done), 32'd0);
      run_op(4'b1000, 4'b0001, 1'b0, "after_rst", 1'b1);

      // Start and reset on the same edge: reset wins.
      rst = 1'b1; start = 1'b1; A = 4'd9; B = 4'd3;
      tick();
      rst = 1'b0; start = 1'b0;
      check("rst_start_busy", 32'(busy), 32'd0);
      tick();

      // All 512 operand combinations in shuffled order.
      for (int i = 0; i < 512; i++) order[i] = i;
      for (int i = 511; i > 0; i--) begin
         int j;
         int tmp;
         j = int'($urandom_range(32'(i), 0));
         tmp = order[i]; order[i] = order[j]; order[j] = tmp;
      end
      for (int i = 0; i < 512; i++) begin
         logic [8:0] v;
         v = 9'(order[i]);
         run_op(v[7:4], v[3:0], v[8], "rnd", 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/serial_sub4.md
# serial_sub4

Bit-serial subtractor, the inverse-direction companion to the team's combinational 4-bit adder `fulladd4`. It accepts two operands plus a borrow-in on a start strobe and resolves one bit per clock, LSB first. It then presents the difference and borrow-out with a one-cycle `done` pulse. It is used where area matters more than latency, and its results are checked against `fulladd4`: A = DIFF + B + Bin.

## Interface
- `WIDTH`, default 4: operand and difference width in bits. Must be ≥ 1. All test values below use 4.
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset. Sampled on the rising edge of `clk`.
- `start`, input, 1: request to begin a subtraction. Sampled only when `busy` = 0.
- `A`, input, WIDTH: minuend. Captured on the accepting edge.
- `B`, input, WIDTH: subtrahend. Captured on the accepting edge.
- `Bin`, input, 1: borrow-in. Captured on the accepting edge.
- `busy`, output, 1: high while a subtraction is in progress.
- `done`, output, 1: single-cycle pulse marking that `DIFF`/`Bout` were just updated.
- `DIFF`, output, WIDTH: difference, registered. Holds its value between operations.
- `Bout`, output, 1: borrow-out, registered. Holds its value between operations.

## Operation
- States:
  - IDLE: `busy` = 0.
  - SHIFT: `busy` = 1.
  - There is no separate DONE state; `done` is a registered flag.
- IDLE with `start` = 1:
  - Capture A, B and Bin into internal shift registers. The captured Bin is the initial borrow.
  - Clear the bit counter to 0 and go to SHIFT.
- IDLE with `start` = 0: hold.
- SHIFT, each cycle, for the current LSB a, b and borrow r:
  - d = a ^ b ^ r
  - r' = (~a & b) | (~(a ^ b) & r)
  - Shift the A and B registers right by one.
  - Shift d into the MSB of the result register.
  - Increment the counter.
- SHIFT, on the cycle that processes bit WIDTH-1:
  - Load `DIFF` with the completed result and `Bout` with r'.
  - Set `done` = 1 and return to IDLE.
- Arithmetic contract:
  - {Bout, DIFF} = ({1'b0, A} − {1'b0, B} − Bin) mod 2^(WIDTH+1).
  - Bout = 1 exactly when A < B + Bin (unsigned).
- `start` while `busy` = 1 is ignored. The operation in flight is unaffected and no request is queued.
- Operand inputs are don't-care except on the accepting edge.
- `DIFF`/`Bout` change only on the completion edge or on reset. Partial results are never visible on the outputs.
- The counter width is ceil(log2(WIDTH)), minimum 1. The counter never wraps past WIDTH-1.

## Timing
- Reset values: `busy` = 0, `done` = 0, `DIFF` = 0, `Bout` = 0, state IDLE. Internal shift registers and counter are cleared.
- Reset has priority over everything, including in SHIFT. The operation is abandoned and no `done` is produced for it.
- Cycle timing for a `start` accepted at edge k:
  - `busy` = 1 after edges k … k+WIDTH−1.
  - Bits are processed at edges k+1 … k+WIDTH.
  - After edge k+WIDTH: `busy` = 0, `done` = 1, `DIFF`/`Bout` are valid.
  - After edge k+WIDTH+1: `done` = 0.
- Latency: WIDTH cycles from the accepting edge to the result (4 for the default width).
- Back-to-back operation: `start` held high during the `done` cycle is accepted, because `busy` = 0 in that cycle. This gives one result every WIDTH+1 cycles.
- `start` and `rst` high on the same edge: reset wins and the request is dropped.

## Test plan
- After reset: `busy`, `done`, `DIFF` and `Bout` all 0. Then A=0000, B=0001, Bin=0 → `DIFF`=1111, `Bout`=1, `done` high exactly 4 cycles after the accepting edge for one cycle.
- A=0011, B=0011, Bin=0 → `DIFF`=0000, `Bout`=0. A=0011, B=0001, Bin=1 → `DIFF`=0001, `Bout`=0.
- A=1111, B=1011, Bin=0 → `DIFF`=0100, `Bout`=0. A=0000, B=0000, Bin=1 → `DIFF`=1111, `Bout`=1.
- Back-to-back: `start` held high continuously.
  - A=0101, B=0010 → 0011.
  - Operands change mid-operation; the change is ignored.
  - Next accept in the `done` cycle with A=0010, B=0101 → 1101, `Bout`=1.
  - `done` pulses are 5 cycles apart.
- Reset mid-operation: pulse `rst` two cycles after start with A=1000, B=0001.
  - No `done` pulse; `DIFF`/`Bout` return to 0.
  - A subsequent operation completes normally.
- Randomized: all 512 A/B/Bin combinations checked against `fulladd4` (A = DIFF + B + Bin) with `Cout` equal to `Bout`.
